mem_handshake: RTL and testbench
================================

MEM_HANDSHAKE -- requirements
Module: mem_handshake

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum cycles in BUSY without mem_ack before the block enters ERR; legal range 1..255.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_read  in  1  read request from the controller, level, held until stall falls.
REQ-005 SHALL have port req_write  in  1  write request from the controller, level, held until stall falls.
REQ-006 SHALL have port addr  in  32  request byte address from the datapath.
REQ-007 SHALL have port wdata  in  32  write data from the datapath.
REQ-008 SHALL have port stall  out  1  freeze the controller's state register while high.
REQ-009 SHALL have port rdata  out  32  registered read data, valid from the DONE cycle until the next read completes.
REQ-010 SHALL have port err  out  1  sticky timeout flag.
REQ-011 SHALL have port mem_req  out  1  memory request, registered.
REQ-012 SHALL have port mem_we  out  1  memory write enable, registered, qualified by mem_req.
REQ-013 SHALL have port mem_addr  out  32  latched address, registered.
REQ-014 SHALL have port mem_wdata  out  32  latched write data, registered.
REQ-015 SHALL have port mem_ack  in  1  single-cycle completion strobe from memory.
REQ-016 SHALL have port mem_rdata  in  32  memory read data, valid in the mem_ack cycle.

Function
REQ-017 SHALL implement the four states IDLE, BUSY, DONE and ERR.
REQ-018 IDLE with req_read or req_write high SHALL move to BUSY on the next edge, latch addr/wdata into mem_addr/mem_wdata, set mem_we = req_write and set mem_req = 1.
REQ-019 When req_read and req_write are both high in IDLE, the write SHALL take priority and the read SHALL be dropped.
REQ-020 stall SHALL be combinational and SHALL be high in IDLE when any request is high, in BUSY, and in ERR; it SHALL be low otherwise.
REQ-021 BUSY with mem_ack high SHALL move to DONE, clear mem_req and mem_we, and capture mem_rdata into rdata for a read only (a write leaves rdata unchanged).
REQ-022 mem_addr, mem_wdata and mem_we SHALL stay stable for the whole time mem_req is high.
REQ-023 DONE SHALL last exactly one cycle with stall low, then move to IDLE; requests seen in DONE SHALL be ignored.
REQ-024 An 8-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without mem_ack.
REQ-025 When the wait counter reaches TIMEOUT with no mem_ack, the block SHALL move to ERR, clear mem_req, and set err.
REQ-026 ERR SHALL be absorbing (exit only by reset), with stall = 1, err = 1 and mem_req = 0; mem_ack in ERR SHALL be ignored.
REQ-027 mem_ack in IDLE, DONE or ERR SHALL have no effect.
REQ-028 Latency SHALL be as follows: request sampled in cycle N, mem_req high from N+1, mem_ack in cycle M (M >= N+1), DONE in M+1; the minimum is 2 stalled cycles.
REQ-029 mem_ack in the same cycle the counter reaches TIMEOUT SHALL take priority, giving DONE rather than ERR.

Reset
REQ-030 While reset = 0, the block SHALL force state IDLE, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rdata = 0, err = 0 and counter = 0, independent of clk.
REQ-031 Reset asserted mid-BUSY SHALL drop mem_req immediately, and a later mem_ack SHALL be ignored.
REQ-032 After reset deasserts, the first request SHALL be accepted on the first rising edge.

Verification
REQ-033 Read, ack on the first BUSY cycle: addr = 0x0000_0010, mem_rdata = 0xDEAD_BEEF -> stall high for 2 cycles; rdata = 0xDEAD_BEEF in DONE; mem_we = 0 throughout.
REQ-034 Write, ack after 3 wait cycles: addr = 0x20, wdata = 0x1234_5678 -> mem_req high for 4 cycles with mem_we = 1 and mem_wdata stable; rdata unchanged; stall low in DONE.
REQ-035 Simultaneous req_read and req_write -> mem_we = 1; only one memory transaction is issued.
REQ-036 No ack with TIMEOUT = 15 -> ERR after 15 BUSY cycles; err = 1, stall stays 1, and a later mem_ack is ignored; reset clears everything.
REQ-037 Ack in the cycle the counter reaches TIMEOUT -> DONE, err = 0.
REQ-038 Reset pulsed low mid-BUSY -> mem_req = 0 without waiting for a clock edge; a late mem_ack is ignored; the next read completes normally.

Source files
------------

// File: rtl/mem_handshake_if.sv
// rtl/mem_handshake_if.sv - controller/datapath/memory signal bundle for mem_handshake
//
// Purpose: groups the request side (controller + datapath) and the memory side
// of the handshake block into one bundle.
// Ports (signals):
//   req_read, req_write  level requests from the controller
//   addr, wdata          request address and write data from the datapath
//   stall                freeze for the controller's state register
//   rdata                registered read data
//   err                  sticky timeout flag
//   mem_req, mem_we      registered memory request / write enable
//   mem_addr, mem_wdata  latched address / write data towards memory
//   mem_ack, mem_rdata   completion strobe and read data from memory
// Modports: slave = the mem_handshake block, master = its environment.

interface mem_handshake_if;
    logic        req_read;
    logic        req_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_read, req_write, addr, wdata, mem_ack, mem_rdata,
        output stall, rdata, err, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_read, req_write, addr, wdata, mem_ack, mem_rdata,
        input  stall, rdata, err, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_handshake.sv
// rtl/mem_handshake.sv - single-outstanding memory request handshake with timeout
//
// Purpose: turns a level read/write request from a controller into one
// registered memory transaction, stalls the controller until it completes,
// and latches a sticky error if memory does not acknowledge in time.
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    mem_handshake_if.slave (request, stall/rdata/err, memory side)
// Parameter:
//   TIMEOUT  BUSY cycles without mem_ack before ERR (1..255)

module mem_handshake #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           reset,
    mem_handshake_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       start;
    logic       timeout_hit;

    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    assign start = (state == IDLE) && (bus.req_read || bus.req_write);

    // The counter holds the number of completed ack-less BUSY cycles, so the
    // current cycle is the TIMEOUT-th one when wait_cnt + 1 equals TIMEOUT.
    // An ack in that same cycle wins, hence the !mem_ack qualifier.
    assign timeout_hit = (state == BUSY) && !bus.mem_ack &&
                         ((wait_cnt + 8'd1) == TIMEOUT_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = BUSY;
            BUSY: begin
                if (bus.mem_ack) begin
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    state_nxt = ERR;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            wait_cnt    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Write wins when both requests are high.
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.req_write;
                        mem_addr_q  <= bus.addr;
                        mem_wdata_q <= bus.wdata;
                        wait_cnt    <= 8'd0;
                    end
                end
                BUSY: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (!mem_we_q) begin
                            rdata_q <= bus.mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        err_q     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Combinational so the controller freezes in the very cycle it requests.
    assign bus.stall = start || (state == BUSY) || (state == ERR);

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_handshake.sv
// tb/tb_mem_handshake.sv - randomized self-checking bench for mem_handshake

module tb_mem_handshake;

    localparam int TO = 15;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    mem_handshake_if bus();

    mem_handshake #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        bus.mem_ack   = 1'b0;
    endtask

    // Assert reset away from any edge, check the forced values without a
    // clock edge, then release on a falling edge.
    task automatic do_reset;
        clear_inputs();
        reset = 1'b0;
        #1;
        m_rdata = 32'd0;
        chk("rst_mem_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_we",    {31'd0, bus.mem_we}, 32'd0);
        chk("rst_mem_addr",  bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_rdata",     bus.rdata, 32'd0);
        chk("rst_err",       {31'd0, bus.err}, 32'd0);
        chk("rst_stall",     {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One transaction: ack arrives in BUSY cycle dly+1; dly >= TO means no ack.
    task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rdv, input int dly);
        bit exp_we;
        exp_we = wr;
        bus.req_read  = rd;
        bus.req_write = wr;
        bus.addr      = a;
        bus.wdata     = wd;
        #1;
        chk("stall_on_req", {31'd0, bus.stall}, 32'd1);
        chk("mem_req_idle", {31'd0, bus.mem_req}, 32'd0);
        tick();
        // Datapath moves on; the latched copies must not follow.
        bus.addr  = $urandom;
        bus.wdata = $urandom;
        for (int k = 1; k <= TO; k++) begin
            chk("busy_mem_req",   {31'd0, bus.mem_req}, 32'd1);
            chk("busy_mem_we",    {31'd0, bus.mem_we}, {31'd0, exp_we});
            chk("busy_mem_addr",  bus.mem_addr, a);
            chk("busy_mem_wdata", bus.mem_wdata, wd);
            chk("busy_stall",     {31'd0, bus.stall}, 32'd1);
            bus.mem_rdata = $urandom;
            if (k == dly + 1) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdv;
            end
            tick();
            bus.mem_ack = 1'b0;
            if (k == dly + 1) break;
        end
        if (dly < TO) begin
            if (!exp_we) m_rdata = rdv;
            chk("done_stall",   {31'd0, bus.stall}, 32'd0);
            chk("done_mem_req", {31'd0, bus.mem_req}, 32'd0);
            chk("done_mem_we",  {31'd0, bus.mem_we}, 32'd0);
            chk("done_rdata",   bus.rdata, m_rdata);
            chk("done_err",     {31'd0, bus.err}, 32'd0);
            // Requests and ack presented during DONE must be ignored.
            bus.req_read  = 1'($urandom);
            bus.req_write = 1'($urandom);
            bus.mem_ack   = 1'($urandom);
            bus.mem_rdata = $urandom;
            tick();
            clear_inputs();
            #1;
            chk("idle_mem_req", {31'd0, bus.mem_req}, 32'd0);
            chk("idle_stall",   {31'd0, bus.stall}, 32'd0);
            chk("idle_rdata",   bus.rdata, m_rdata);
            // Ack while IDLE has no effect either.
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = $urandom;
            tick();
            bus.mem_ack = 1'b0;
            chk("idle_ack_rdata",   bus.rdata, m_rdata);
            chk("idle_ack_mem_req", {31'd0, bus.mem_req}, 32'd0);
        end else begin
            clear_inputs();
            #1;
            chk("err_flag",    {31'd0, bus.err}, 32'd1);
            chk("err_stall",   {31'd0, bus.stall}, 32'd1);
            chk("err_mem_req", {31'd0, bus.mem_req}, 32'd0);
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rdv;
            tick();
            bus.mem_ack = 1'b0;
            chk("err_late_ack_err",   {31'd0, bus.err}, 32'd1);
            chk("err_late_ack_stall", {31'd0, bus.stall}, 32'd1);
            chk("err_late_ack_rdata", bus.rdata, m_rdata);
            do_reset();
        end
    endtask

    initial begin
        reset         = 1'b0;
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        bus.addr      = 32'd0;
        bus.wdata     = 32'd0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        m_rdata       = 32'd0;
        #2;
        do_reset();

        txn(1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0);
        txn(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hCAFE_F00D, 3);
        txn(1'b1, 1'b1, 32'h0000_0030, 32'hA5A5_5A5A, 32'h1111_2222, 1);
        txn(1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'h3333_4444, TO);
        txn(1'b1, 1'b0, 32'h0000_0050, 32'h0,         32'h5555_6666, TO - 1);

        // Reset pulsed mid-BUSY: mem_req must fall without a clock edge.
        bus.req_read = 1'b1;
        bus.addr     = 32'h0000_0060;
        tick();
        tick();
        bus.req_read = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        m_rdata = 32'd0;
        chk("midrst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("midrst_stall",   {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        reset         = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h7777_8888;
        tick();
        bus.mem_ack = 1'b0;
        chk("midrst_late_ack_rdata",   bus.rdata, 32'd0);
        chk("midrst_late_ack_mem_req", {31'd0, bus.mem_req}, 32'd0);
        txn(1'b1, 1'b0, 32'h0000_0070, 32'h0, 32'h9999_AAAA, 2);

        for (int i = 0; i < 150; i++) begin
            int  sel;
            int  dly;
            bit  rd;
            bit  wr;
            sel = $urandom_range(0, 2);
            rd  = (sel != 1);
            wr  = (sel != 0);
            if ($urandom_range(0, 9) == 0) dly = $urandom_range(TO, TO + 3);
            else if ($urandom_range(0, 7) == 0) dly = TO - 1;
            else dly = $urandom_range(0, TO - 1);
            txn(rd, wr, $urandom, $urandom, $urandom, dly);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
